// File: rtl/colour_output_pkg.sv
// Shared definitions for the gate-array colour output stage: write function codes,
// screen modes and the CPC hardware-colour to RGB-level table.
package colour_output_pkg;

    typedef enum logic [1:0] {
        FN_PEN  = 2'b00,
        FN_INK  = 2'b01,
        FN_MODE = 2'b10,
        FN_NONE = 2'b11
    } wr_fn_e;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_e;

    localparam int unsigned PALETTE_DEPTH = 17;
    localparam logic [4:0]  BORDER_PEN    = 5'd16;

    // Each entry is {red, green, blue}, two bits per channel: 00 off, 01 half, 10 full.
    localparam logic [5:0] COLOUR_TABLE [32] = '{
        6'b01_01_01, 6'b01_01_01, 6'b00_10_01, 6'b10_10_01,  // 00-03
        6'b00_00_01, 6'b10_00_01, 6'b00_01_01, 6'b10_01_01,  // 04-07
        6'b10_00_01, 6'b10_10_01, 6'b10_10_00, 6'b10_10_10,  // 08-0B
        6'b10_00_00, 6'b10_00_10, 6'b10_01_00, 6'b10_01_10,  // 0C-0F
        6'b00_00_01, 6'b00_10_01, 6'b00_10_00, 6'b00_10_10,  // 10-13
        6'b00_00_00, 6'b00_00_10, 6'b00_01_00, 6'b00_01_10,  // 14-17
        6'b01_00_01, 6'b01_10_01, 6'b01_10_00, 6'b01_10_10,  // 18-1B
        6'b01_00_00, 6'b01_00_10, 6'b01_01_00, 6'b01_01_10   // 1C-1F
    };

    function automatic logic [5:0] colour_rgb(input logic [4:0] hw_colour);
        return COLOUR_TABLE[hw_colour];
    endfunction

endpackage

// File: rtl/colour_output_if.sv
// CPU-side gate-array register write bus: a one-cycle strobe plus 8-bit data.
interface colour_output_if;
    logic       WR_STB;
    logic [7:0] WR_DATA;

    modport master (output WR_STB, output WR_DATA);
    modport slave  (input  WR_STB, input  WR_DATA);
endinterface

// File: rtl/colour_output_palette_ram.sv
// 17-entry ink palette: one synchronous write port, one asynchronous read port.
module colour_output_palette_ram
    import colour_output_pkg::*;
#(
    parameter logic [4:0] RESET_INK = 5'h14
) (
    input  logic       CLK_n,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [4:0] wr_ink,
    input  logic [4:0] rd_addr,
    output logic [4:0] rd_ink
);

    logic [4:0] mem [PALETTE_DEPTH];

    // NOTE: this small register file is deliberately reset entry by entry; a large
    // RAM would normally have no reset, but the palette must power up as black.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            for (int i = 0; i < PALETTE_DEPTH; i++) mem[i] <= RESET_INK;
        end else if (wr_en && (wr_addr <= BORDER_PEN)) begin
            mem[wr_addr] <= wr_ink;
        end
    end

    assign rd_ink = (rd_addr <= BORDER_PEN) ? mem[rd_addr] : RESET_INK;

endmodule

// File: rtl/colour_output.sv
// Gate-array colour output: pen/ink/mode registers, HSYNC-aligned mode switch and a
// two-register pixel pipeline from shifter pen index to RGB levels.
module colour_output
    import colour_output_pkg::*;
#(
    parameter logic [4:0] RESET_INK  = 5'h14,
    parameter logic [1:0] RESET_MODE = 2'd1
) (
    input  logic                  CLK_n,
    input  logic                  RESET,
    colour_output_if.slave        wr_bus,
    input  logic [3:0]            CIDX,
    input  logic                  PIX_STB,
    input  logic                  BORDER,
    input  logic                  BLANK,
    input  logic                  HSYNC,
    output logic [1:0]            MODE,
    output logic [1:0]            RED,
    output logic [1:0]            GREEN,
    output logic [1:0]            BLUE
);

    wr_fn_e     wr_fn;
    logic [4:0] pen_sel;
    mode_e      pending_mode;
    mode_e      active_mode;
    logic       hsync_q;
    logic       hsync_rise;

    logic [3:0] pen_next;
    logic [3:0] pen_q;
    logic       border_q;
    logic       blank_q;

    logic [4:0] rd_addr;
    logic [4:0] rd_ink;
    logic [5:0] rgb_next;
    logic [5:0] rgb_q;
    logic       ink_wr;
    logic       unused_wr_bits;

    assign wr_fn          = wr_fn_e'(wr_bus.WR_DATA[7:6]);
    assign ink_wr         = wr_bus.WR_STB && (wr_fn == FN_INK);
    assign hsync_rise     = HSYNC && !hsync_q;
    assign unused_wr_bits = wr_bus.WR_DATA[5];

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; that is what makes a same-cycle mode write miss the HSYNC edge.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            pen_sel      <= 5'd0;
            pending_mode <= mode_e'(RESET_MODE);
            active_mode  <= mode_e'(RESET_MODE);
            hsync_q      <= 1'b0;
        end else begin
            hsync_q <= HSYNC;
            if (hsync_rise) active_mode <= pending_mode;
            if (wr_bus.WR_STB) begin
                case (wr_fn)
                    FN_PEN:  pen_sel      <= wr_bus.WR_DATA[4] ? BORDER_PEN : {1'b0, wr_bus.WR_DATA[3:0]};
                    FN_MODE: pending_mode <= mode_e'(wr_bus.WR_DATA[1:0]);
                    default: ;
                endcase
            end
        end
    end

    colour_output_palette_ram #(
        .RESET_INK (RESET_INK)
    ) u_palette (
        .CLK_n   (CLK_n),
        .RESET   (RESET),
        .wr_en   (ink_wr),
        .wr_addr (pen_sel),
        .wr_ink  (wr_bus.WR_DATA[4:0]),
        .rd_addr (rd_addr),
        .rd_ink  (rd_ink)
    );

    // NOTE: every path assigns pen_next first, so no latch can be inferred.
    always_comb begin
        pen_next = CIDX;
        case (active_mode)
            MODE_0:  pen_next = CIDX;
            MODE_2:  pen_next = {3'b000, CIDX[0]};
            default: pen_next = {2'b00, CIDX[1:0]};
        endcase
    end

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            pen_q    <= 4'd0;
            border_q <= 1'b0;
            blank_q  <= 1'b0;
        end else if (PIX_STB) begin
            pen_q    <= pen_next;
            border_q <= BORDER;
            blank_q  <= BLANK;
        end
    end

    // The palette is read live, so an ink write shows on the very next output register.
    assign rd_addr  = border_q ? BORDER_PEN : {1'b0, pen_q};
    assign rgb_next = blank_q ? 6'd0 : colour_rgb(rd_ink);

    always_ff @(posedge CLK_n) begin
        if (RESET) rgb_q <= 6'd0;
        else       rgb_q <= rgb_next;
    end

    assign MODE  = active_mode;
    assign RED   = rgb_q[5:4];
    assign GREEN = rgb_q[3:2];
    assign BLUE  = rgb_q[1:0];

endmodule

// File: tb/tb_colour_output.sv
// Directed bench for colour_output: vector table for pixel lookups plus hand-written
// sequences for mode switching, mid-line ink rewrites and reset.
module tb_colour_output;

    logic       CLK_n = 1'b0;
    logic       RESET;
    logic [3:0] CIDX;
    logic       PIX_STB;
    logic       BORDER;
    logic       BLANK;
    logic       HSYNC;
    logic [1:0] MODE;
    logic [1:0] RED;
    logic [1:0] GREEN;
    logic [1:0] BLUE;
    logic [5:0] rgb;

    colour_output_if bus ();

    colour_output dut (
        .CLK_n   (CLK_n),
        .RESET   (RESET),
        .wr_bus  (bus),
        .CIDX    (CIDX),
        .PIX_STB (PIX_STB),
        .BORDER  (BORDER),
        .BLANK   (BLANK),
        .HSYNC   (HSYNC),
        .MODE    (MODE),
        .RED     (RED),
        .GREEN   (GREEN),
        .BLUE    (BLUE)
    );

    assign rgb = {RED, GREEN, BLUE};

    always #5 CLK_n = ~CLK_n;

    typedef struct {
        logic [1:0] mode;
        logic       border;
        logic       blank;
        logic [3:0] cidx;
        logic [5:0] rgb;
    } vec_t;

    vec_t vecs [12];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Advance past a rising edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge CLK_n);
        #1;
    endtask

    task automatic wr(input logic [7:0] data);
        bus.WR_STB  = 1'b1;
        bus.WR_DATA = data;
        tick();
        bus.WR_STB  = 1'b0;
    endtask

    task automatic pixel(input logic border, input logic blank, input logic [3:0] cidx);
        BORDER  = border;
        BLANK   = blank;
        CIDX    = cidx;
        PIX_STB = 1'b1;
        tick();
        PIX_STB = 1'b0;
        tick();
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            pixel(vecs[i].border, vecs[i].blank, vecs[i].cidx);
            check($sformatf("vec%0d_rgb", i), {2'b00, rgb}, {2'b00, vecs[i].rgb});
            check($sformatf("vec%0d_mode", i), {6'd0, MODE}, {6'd0, vecs[i].mode});
        end
    endtask

    initial begin
        // Palette after setup: pen0=15, pen1=04, pen3=0C, pen9=0E, border=0B, rest=14.
        vecs[0]  = '{2'd1, 1'b1, 1'b0, 4'd5,     6'b10_10_10};
        vecs[1]  = '{2'd1, 1'b1, 1'b1, 4'd3,     6'b00_00_00};
        vecs[2]  = '{2'd1, 1'b0, 1'b1, 4'd3,     6'b00_00_00};
        vecs[3]  = '{2'd1, 1'b0, 1'b0, 4'b1011,  6'b10_00_00};
        vecs[4]  = '{2'd1, 1'b0, 1'b0, 4'b1001,  6'b00_00_01};
        vecs[5]  = '{2'd1, 1'b0, 1'b0, 4'b0100,  6'b00_00_10};
        vecs[6]  = '{2'd1, 1'b0, 1'b0, 4'b1110,  6'b00_00_00};
        vecs[7]  = '{2'd0, 1'b0, 1'b0, 4'd9,     6'b10_01_00};
        vecs[8]  = '{2'd0, 1'b0, 1'b0, 4'd3,     6'b10_00_00};
        vecs[9]  = '{2'd0, 1'b0, 1'b0, 4'b1011,  6'b00_00_00};
        vecs[10] = '{2'd2, 1'b0, 1'b0, 4'b1110,  6'b00_00_10};
        vecs[11] = '{2'd2, 1'b0, 1'b0, 4'b0001,  6'b00_00_01};

        RESET       = 1'b1;
        bus.WR_STB  = 1'b0;
        bus.WR_DATA = 8'h00;
        CIDX        = 4'd0;
        PIX_STB     = 1'b0;
        BORDER      = 1'b0;
        BLANK       = 1'b0;
        HSYNC       = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        check("reset_mode", {6'd0, MODE}, 8'd1);
        check("reset_rgb", {2'b00, rgb}, 8'd0);

        pixel(1'b0, 1'b0, 4'd5);
        check("reset_ink_black", {2'b00, rgb}, 8'd0);

        wr(8'h03);
        wr(8'h4C);
        pixel(1'b0, 1'b0, 4'b0111);
        check("pen3_bright_red", {2'b00, rgb}, {2'b00, 6'b10_00_00});

        wr(8'h10); wr(8'h4B);
        wr(8'h09); wr(8'h4E);
        wr(8'h01); wr(8'h44);
        wr(8'h00); wr(8'h55);
        run_vecs(0, 6);

        // Mode write is deferred until the next HSYNC rising edge.
        wr(8'h80);
        check("mode_after_write", {6'd0, MODE}, 8'd1);
        tick();
        check("mode_before_hsync", {6'd0, MODE}, 8'd1);
        HSYNC = 1'b1;
        tick();
        check("mode_after_hsync", {6'd0, MODE}, 8'd0);
        HSYNC = 1'b0;
        tick();
        run_vecs(7, 9);

        // Mode write in the HSYNC-rise cycle: old pending value wins.
        bus.WR_STB  = 1'b1;
        bus.WR_DATA = 8'h82;
        HSYNC       = 1'b1;
        tick();
        bus.WR_STB  = 1'b0;
        check("same_cycle_old_pending", {6'd0, MODE}, 8'd0);
        HSYNC = 1'b0;
        tick();
        HSYNC = 1'b1;
        tick();
        check("next_hsync_new_mode", {6'd0, MODE}, 8'd2);
        wr(8'h81);
        tick();
        check("hsync_level_no_retrigger", {6'd0, MODE}, 8'd2);
        HSYNC = 1'b0;
        tick();
        run_vecs(10, 11);

        // Rewrite the ink of the pen on screen: output follows one cycle after the write.
        wr(8'h01);
        check("before_ink_rewrite", {2'b00, rgb}, {2'b00, 6'b00_00_01});
        bus.WR_STB  = 1'b1;
        bus.WR_DATA = 8'h4C;
        tick();
        bus.WR_STB  = 1'b0;
        check("ink_write_edge", {2'b00, rgb}, {2'b00, 6'b00_00_01});
        tick();
        check("ink_rewrite_visible", {2'b00, rgb}, {2'b00, 6'b10_00_00});

        // Reset with a simultaneous ink write and pixel strobe.
        RESET       = 1'b1;
        bus.WR_STB  = 1'b1;
        bus.WR_DATA = 8'h4B;
        PIX_STB     = 1'b1;
        CIDX        = 4'd1;
        tick();
        RESET      = 1'b0;
        bus.WR_STB = 1'b0;
        PIX_STB    = 1'b0;
        check("midline_reset_rgb", {2'b00, rgb}, 8'd0);
        check("midline_reset_mode", {6'd0, MODE}, 8'd1);
        pixel(1'b0, 1'b0, 4'd1);
        check("reset_write_lost", {2'b00, rgb}, 8'd0);
        pixel(1'b0, 1'b0, 4'd3);
        check("reset_palette_pen3", {2'b00, rgb}, 8'd0);
        wr(8'h4C);
        pixel(1'b0, 1'b0, 4'd0);
        check("reset_pen_sel_zero", {2'b00, rgb}, {2'b00, 6'b10_00_00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
